// File: rtl/algo_nror1w_dup_core.sv
// algo_nror1w_dup_core
// Functional core of a 1-write / NUMRDPT-read memory built by duplicating every
// virtual bank once per read port. After reset all copies are zero-filled, then
// writes go to every copy of a bank and read port p reads its private copy.
module algo_nror1w_dup_core #(
    parameter int WIDTH      = 32,
    parameter int NUMRDPT    = 2,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int NUMVBNK    = 8,
    parameter int BITVBNK    = 3,
    parameter int NUMVROW    = 1024,
    parameter int BITVROW    = 10,
    parameter int BITPADR    = 13,
    parameter int SRAM_DELAY = 2,
    parameter int FLOPIN     = 0,
    parameter int FLOPOUT    = 0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    output logic                                       ready,
    input  logic                                       write,
    input  logic [BITADDR-1:0]                         wr_adr,
    input  logic [WIDTH-1:0]                           din,
    input  logic [NUMRDPT-1:0]                         read,
    input  logic [NUMRDPT*BITADDR-1:0]                 rd_adr,
    output logic [NUMRDPT-1:0]                         rd_vld,
    output logic [NUMRDPT*WIDTH-1:0]                   rd_dout,
    output logic [NUMRDPT-1:0]                         rd_fwrd,
    output logic [NUMRDPT-1:0]                         rd_serr,
    output logic [NUMRDPT-1:0]                         rd_derr,
    output logic [NUMRDPT*BITPADR-1:0]                 rd_padr,
    output logic [NUMRDPT*NUMVBNK-1:0]                 t1_readA,
    output logic [NUMRDPT*NUMVBNK-1:0]                 t1_writeA,
    output logic [NUMRDPT*NUMVBNK*BITVROW-1:0]         t1_addrA,
    output logic [NUMRDPT*NUMVBNK*WIDTH-1:0]           t1_dinA,
    input  logic [NUMRDPT*NUMVBNK*WIDTH-1:0]           t1_doutA,
    input  logic [NUMRDPT*NUMVBNK-1:0]                 t1_fwrdA,
    input  logic [NUMRDPT*NUMVBNK-1:0]                 t1_serrA,
    input  logic [NUMRDPT*NUMVBNK-1:0]                 t1_derrA,
    input  logic [NUMRDPT*NUMVBNK*(BITPADR-BITVBNK)-1:0] t1_padrA
);

    localparam int NUMCOPY = NUMRDPT * NUMVBNK;
    localparam int BITPROW = BITPADR - BITVBNK;

    // Bank of a logical address (rows per bank need not be a power of two)
    function automatic logic [BITVBNK-1:0] np2_bank(input logic [BITADDR-1:0] adr);
        return BITVBNK'(adr / BITADDR'(NUMVROW));
    endfunction

    // Row within the bank of a logical address
    function automatic logic [BITVROW-1:0] np2_row(input logic [BITADDR-1:0] adr);
        return BITVROW'(adr % BITADDR'(NUMVROW));
    endfunction

    function automatic logic adr_in_range(input logic [BITADDR-1:0] adr);
        return ({1'b0, adr} < (BITADDR+1)'(NUMADDR));
    endfunction

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    state_t               state_r;
    logic [BITVROW-1:0]   init_row_r;
    logic                 ready_r;

    // Init sequencer: sweep every row once with zero writes, then stay ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            init_row_r <= '0;
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_row_r == BITVROW'(NUMVROW - 1)) begin
                        state_r    <= ST_READY;
                        init_row_r <= '0;
                        ready_r    <= 1'b1;
                    end else begin
                        init_row_r <= init_row_r + BITVROW'(1);
                    end
                end
                ST_READY: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_row_r <= '0;
                    ready_r    <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;

    // Requests seen while not ready are discarded before (and after) any input stage
    logic                         wr_req_s;
    logic [NUMRDPT-1:0]           rd_req_s;
    logic                         wr_req_q;
    logic [BITADDR-1:0]           wr_adr_q;
    logic [WIDTH-1:0]             din_q;
    logic [NUMRDPT-1:0]           rd_req_q;
    logic [NUMRDPT*BITADDR-1:0]   rd_adr_q;

    assign wr_req_s = write & ready_r;
    assign rd_req_s = read & {NUMRDPT{ready_r}};

    generate
        if (FLOPIN != 0) begin : g_flopin
            logic                       wr_req_r;
            logic [BITADDR-1:0]         wr_adr_r;
            logic [WIDTH-1:0]           din_r;
            logic [NUMRDPT-1:0]         rd_req_r;
            logic [NUMRDPT*BITADDR-1:0] rd_adr_r;

            // Input register stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_req_r <= 1'b0;
                    wr_adr_r <= '0;
                    din_r    <= '0;
                    rd_req_r <= '0;
                    rd_adr_r <= '0;
                end else begin
                    wr_req_r <= wr_req_s;
                    wr_adr_r <= wr_adr;
                    din_r    <= din;
                    rd_req_r <= rd_req_s;
                    rd_adr_r <= rd_adr;
                end
            end

            assign wr_req_q = wr_req_r & ready_r;
            assign wr_adr_q = wr_adr_r;
            assign din_q    = din_r;
            assign rd_req_q = rd_req_r & {NUMRDPT{ready_r}};
            assign rd_adr_q = rd_adr_r;
        end else begin : g_direct
            assign wr_req_q = wr_req_s;
            assign wr_adr_q = wr_adr;
            assign din_q    = din;
            assign rd_req_q = rd_req_s;
            assign rd_adr_q = rd_adr;
        end
    endgenerate

    logic                 wr_go_s;
    logic [BITVBNK-1:0]   wr_bank_s;
    logic [BITVROW-1:0]   wr_row_s;
    logic [NUMRDPT-1:0]   rd_go_s;
    logic [BITVBNK-1:0]   rd_bank_s [NUMRDPT];
    logic [BITVROW-1:0]   rd_row_s  [NUMRDPT];

    // Decode requests; a write request pre-empts every read of the same cycle
    always_comb begin
        wr_go_s   = wr_req_q & adr_in_range(wr_adr_q);
        wr_bank_s = np2_bank(wr_adr_q);
        wr_row_s  = np2_row(wr_adr_q);
        rd_go_s   = '0;
        for (int p = 0; p < NUMRDPT; p++) begin
            rd_bank_s[p] = np2_bank(rd_adr_q[p*BITADDR +: BITADDR]);
            rd_row_s[p]  = np2_row(rd_adr_q[p*BITADDR +: BITADDR]);
            rd_go_s[p]   = rd_req_q[p] & adr_in_range(rd_adr_q[p*BITADDR +: BITADDR]) & ~wr_req_q;
        end
    end

    // Drive the copies: zero fill during init, otherwise write all copies of a bank or per-port reads
    always_comb begin
        t1_readA  = '0;
        t1_writeA = '0;
        t1_addrA  = '0;
        t1_dinA   = '0;
        if (rst) begin
            t1_writeA = '0;
        end else if (state_r == ST_INIT) begin
            t1_writeA = '1;
            for (int k = 0; k < NUMCOPY; k++) begin
                t1_addrA[k*BITVROW +: BITVROW] = init_row_r;
            end
        end else if (wr_go_s) begin
            for (int p = 0; p < NUMRDPT; p++) begin
                t1_writeA[NUMRDPT*int'(wr_bank_s)+p]                       = 1'b1;
                t1_addrA[(NUMRDPT*int'(wr_bank_s)+p)*BITVROW +: BITVROW]  = wr_row_s;
                t1_dinA[(NUMRDPT*int'(wr_bank_s)+p)*WIDTH +: WIDTH]       = din_q;
            end
        end else begin
            for (int p = 0; p < NUMRDPT; p++) begin
                t1_readA[NUMRDPT*int'(rd_bank_s[p])+p]                      = rd_go_s[p];
                t1_addrA[(NUMRDPT*int'(rd_bank_s[p])+p)*BITVROW +: BITVROW] =
                    rd_go_s[p] ? rd_row_s[p] : '0;
            end
        end
    end

    logic [SRAM_DELAY-1:0] pvld_r [NUMRDPT];
    logic [BITVBNK-1:0]    pbnk_r [NUMRDPT][SRAM_DELAY];

    // Per-port read pipeline carrying valid and bank across the SRAM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUMRDPT; p++) begin
                pvld_r[p] <= '0;
                for (int s = 0; s < SRAM_DELAY; s++) begin
                    pbnk_r[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUMRDPT; p++) begin
                pvld_r[p][0] <= rd_go_s[p];
                pbnk_r[p][0] <= rd_bank_s[p];
                for (int s = 1; s < SRAM_DELAY; s++) begin
                    pvld_r[p][s] <= pvld_r[p][s-1];
                    pbnk_r[p][s] <= pbnk_r[p][s-1];
                end
            end
        end
    end

    logic [NUMRDPT-1:0]         rd_vld_s;
    logic [NUMRDPT*WIDTH-1:0]   rd_dout_s;
    logic [NUMRDPT-1:0]         rd_fwrd_s;
    logic [NUMRDPT-1:0]         rd_serr_s;
    logic [NUMRDPT-1:0]         rd_derr_s;
    logic [NUMRDPT*BITPADR-1:0] rd_padr_s;

    // Select the owning copy's return data; outputs stay zero unless a read is due
    always_comb begin
        rd_vld_s  = '0;
        rd_dout_s = '0;
        rd_fwrd_s = '0;
        rd_serr_s = '0;
        rd_derr_s = '0;
        rd_padr_s = '0;
        for (int p = 0; p < NUMRDPT; p++) begin
            if (pvld_r[p][SRAM_DELAY-1] && !rst) begin
                rd_vld_s[p]                       = 1'b1;
                rd_dout_s[p*WIDTH +: WIDTH]       =
                    t1_doutA[(NUMRDPT*int'(pbnk_r[p][SRAM_DELAY-1])+p)*WIDTH +: WIDTH];
                rd_fwrd_s[p] = t1_fwrdA[NUMRDPT*int'(pbnk_r[p][SRAM_DELAY-1])+p];
                rd_serr_s[p] = t1_serrA[NUMRDPT*int'(pbnk_r[p][SRAM_DELAY-1])+p];
                rd_derr_s[p] = t1_derrA[NUMRDPT*int'(pbnk_r[p][SRAM_DELAY-1])+p];
                rd_padr_s[p*BITPADR +: BITPADR]   = {pbnk_r[p][SRAM_DELAY-1],
                    t1_padrA[(NUMRDPT*int'(pbnk_r[p][SRAM_DELAY-1])+p)*BITPROW +: BITPROW]};
            end else begin
                rd_vld_s[p] = 1'b0;
            end
        end
    end

    generate
        if (FLOPOUT != 0) begin : g_flopout
            // Output register stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_vld  <= '0;
                    rd_dout <= '0;
                    rd_fwrd <= '0;
                    rd_serr <= '0;
                    rd_derr <= '0;
                    rd_padr <= '0;
                end else begin
                    rd_vld  <= rd_vld_s;
                    rd_dout <= rd_dout_s;
                    rd_fwrd <= rd_fwrd_s;
                    rd_serr <= rd_serr_s;
                    rd_derr <= rd_derr_s;
                    rd_padr <= rd_padr_s;
                end
            end
        end else begin : g_comb_out
            assign rd_vld  = rd_vld_s;
            assign rd_dout = rd_dout_s;
            assign rd_fwrd = rd_fwrd_s;
            assign rd_serr = rd_serr_s;
            assign rd_derr = rd_derr_s;
            assign rd_padr = rd_padr_s;
        end
    endgenerate

endmodule
